// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN layer-1 -> layer-2 window reader.
package cnn_pkg;
  localparam int DATA_W = 13;
  localparam int L_DEF  = 10;
  localparam int S_DEF  = 6;
  localparam int K_DEF  = 3;
  localparam int NWIN   = (S_DEF - K_DEF + 1) * (S_DEF - K_DEF + 1);

  typedef enum logic [1:0] {ST_FILL, ST_STREAM, ST_DONE} state_t;

  // clog2 that never collapses to a zero-width counter
  function automatic int clog2_1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fmap_ram.sv
// Feature-map buffer: one synchronous write port, one registered read port.
module fmap_ram #(
  parameter int DW    = 130,
  parameter int DEPTH = 36,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)    mem[wr_addr] <= wr_data;
    if (rd_en) rd_data      <= mem[rd_addr];
  end
endmodule

// File: rtl/pool_fmap_window_reader.sv
// Captures an S x S pooled map (L lanes) and replays it as K x K sliding windows.
module pool_fmap_window_reader
  import cnn_pkg::*;
#(
  parameter int L = L_DEF,
  parameter int S = S_DEF,
  parameter int K = K_DEF,
  parameter int W = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [L*W-1:0]        in_data,
  output logic [L*W-1:0]        win_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  win_first,
  output logic                  win_last,
  output logic [clog2_1(S)-1:0] win_row,
  output logic [clog2_1(S)-1:0] win_col,
  output logic                  buf_full,
  output logic                  ovf,
  output logic                  done
);
  localparam int AW     = clog2_1(S*S);
  localparam int PW     = clog2_1(S);
  localparam int RW     = clog2_1(S-K+1);
  localparam int KW     = clog2_1(K);
  localparam int STAGES = 2;

  state_t          state;
  logic [AW-1:0]   wr_ptr, rd_addr;
  logic [RW-1:0]   r, c;
  logic [KW-1:0]   kr, kc;
  // [0]: address pending issue, [1]: RAM output register, [2]: output beat
  logic [STAGES:0] vld_pipe;
  logic            s1_first, s1_last;
  logic [PW-1:0]   s1_row, s1_col;
  logic [L*W-1:0]  ram_q;
  logic            we, adv, rd_en, kc_end, kr_end, fin;

  always_comb begin
    we      = in_valid && (state == ST_FILL) && !rst;
    adv     = !win_valid || win_ready;
    rd_en   = adv && vld_pipe[0];
    kc_end  = (kc == KW'(K-1));
    kr_end  = (kr == KW'(K-1));
    rd_addr = AW'((int'(r) + int'(kr)) * S + int'(c) + int'(kc));
    fin     = win_valid && win_ready && win_last &&
              (win_row == PW'(S-K)) && (win_col == PW'(S-K));
  end

  assign win_valid = vld_pipe[STAGES];

  fmap_ram #(.DW(L*W), .DEPTH(S*S), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FILL;
      wr_ptr    <= '0;
      r         <= '0;
      c         <= '0;
      kr        <= '0;
      kc        <= '0;
      vld_pipe  <= '0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      win_data  <= '0;
      win_first <= 1'b0;
      win_last  <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      buf_full  <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (in_valid && state != ST_FILL) ovf <= 1'b1;
      case (state)
        ST_FILL: if (in_valid) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == AW'(S*S-1)) begin
            buf_full    <= 1'b1;
            vld_pipe[0] <= 1'b1;
            state       <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (rd_en) begin
            if (!kc_end) kc <= kc + 1'b1;
            else begin
              kc <= '0;
              if (!kr_end) kr <= kr + 1'b1;
              else begin
                kr <= '0;
                if (c != RW'(S-K)) c <= c + 1'b1;
                else begin
                  c <= '0;
                  if (r != RW'(S-K)) r <= r + 1'b1;
                  else vld_pipe[0] <= 1'b0;
                end
              end
            end
          end
          // Whole read pipe moves as one; a stalled output freezes the RAM register too
          if (adv) begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            s1_first  <= (kr == '0) && (kc == '0);
            s1_last   <= kr_end && kc_end;
            s1_row    <= PW'(r);
            s1_col    <= PW'(c);
            win_data  <= ram_q;
            win_first <= s1_first;
            win_last  <= s1_last;
            win_row   <= s1_row;
            win_col   <= s1_col;
          end
          if (fin) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            vld_pipe <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_fmap_window_reader.sv
// Directed bench: fills maps, streams windows under several ready patterns, checks against a pixel model.
module tb_pool_fmap_window_reader;
  import cnn_pkg::*;

  localparam int L  = 10;
  localparam int S  = 6;
  localparam int K  = 3;
  localparam int W  = 13;
  localparam int NO = S - K + 1;
  localparam int NB = NWIN * K * K;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic [L*W-1:0] in_data = '0;
  logic [L*W-1:0] win_data;
  logic           win_valid, win_ready = 1'b0, win_first, win_last;
  logic [2:0]     win_row, win_col;
  logic           buf_full, ovf, done;

  int n_tests = 0;
  int n_fail  = 0;
  int px [S*S][L];

  pool_fmap_window_reader #(.L(L), .S(S), .K(K), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .win_data  (win_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_first (win_first),
    .win_last  (win_last),
    .win_row   (win_row),
    .win_col   (win_col),
    .buf_full  (buf_full),
    .ovf       (ovf),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pix(input int pat, input int i, input int ch);
    case (pat)
      0:       return ch * 100 + i;
      1:       return ((ch + i) % 2) ? 4095 : -4096;
      default: return -(ch * 100 + i) - 1;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;  // strobe under reset must be ignored
    win_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(win_valid), 0);
    chk({tag, "_data"},  int'(win_data == '0), 1);
    chk({tag, "_first"}, int'(win_first), 0);
    chk({tag, "_last"},  int'(win_last), 0);
    chk({tag, "_row"},   int'(win_row), 0);
    chk({tag, "_col"},   int'(win_col), 0);
    chk({tag, "_full"},  int'(buf_full), 0);
    chk({tag, "_ovf"},   int'(ovf), 0);
    chk({tag, "_done"},  int'(done), 0);
  endtask

  // gap < 0 selects a random 0..2 cycle gap per pixel
  task automatic fill(input int pat, input int gap);
    for (int i = 0; i < S*S; i++) begin
      if (i == S*S-1) chk("full_early", int'(buf_full), 0);
      in_valid = 1'b1;
      for (int ch = 0; ch < L; ch++) begin
        px[i][ch] = pix(pat, i, ch);
        in_data[ch*W +: W] = W'(px[i][ch]);
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (i < S*S-1) repeat ((gap < 0) ? $urandom_range(0, 2) : gap) @(negedge clk);
    end
    chk("full_set", int'(buf_full), 1);
  endtask

  task automatic chk_beat(input int idx);
    int w, e, rr, cc, kr, kc, a;
    w = idx / (K*K);  e = idx % (K*K);
    rr = w / NO;      cc = w % NO;
    kr = e / K;       kc = e % K;
    a = (rr + kr) * S + cc + kc;
    chk("first", int'(win_first), int'(e == 0));
    chk("last",  int'(win_last),  int'(e == K*K-1));
    chk("row",   int'(win_row),   rr);
    chk("col",   int'(win_col),   cc);
    for (int ch = 0; ch < L; ch++)
      chk($sformatf("data_b%0d_c%0d", idx, ch), int'($signed(win_data[ch*W +: W])), px[a][ch]);
  endtask

  // Streams until stop_after beats are accepted; stray_at injects one in_valid at that beat index
  task automatic run_stream(input bit rnd, input int stop_after, input int stray_at);
    int  idx = 0, cyc = 0;
    bit  seen = 0, strayed = 0;
    while (idx < stop_after && cyc < 3000) begin
      win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = 1'b0;
      if (idx == stray_at && !strayed) begin
        strayed = 1;
        in_valid = 1'b1;
        for (int ch = 0; ch < L; ch++) in_data[ch*W +: W] = W'($urandom);
      end
      if (win_valid) begin
        seen = 1;
        chk_beat(idx);
        if (win_ready) idx++;
      end else if (!rnd && seen) begin
        chk("valid_gap", int'(win_valid), 1);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("beats", idx, stop_after);
  endtask

  task automatic chk_done();
    chk("done",       int'(done), 1);
    chk("done_valid", int'(win_valid), 0);
    chk("done_full",  int'(buf_full), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: ready tied high, pixel every other cycle, latency and continuity
    do_reset();
    chk_zero("rst1");
    win_ready = 1'b1;
    fill(0, 1);
    chk("lat0", int'(win_valid), 0);
    @(negedge clk);
    chk("lat1", int'(win_valid), 0);
    @(negedge clk);
    chk("lat2", int'(win_valid), 1);
    run_stream(0, NB, -1);
    chk_done();
    chk("ovf_clean", int'(ovf), 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_done", int'(ovf), 1);
    chk_done();

    // 2: random backpressure, irregular input gaps, stray strobe mid-stream
    do_reset();
    chk_zero("rst2");
    fill(0, -1);
    run_stream(1, NB, 70);
    chk_done();
    chk("ovf_stream", int'(ovf), 1);

    // 3: signed extremes
    do_reset();
    fill(1, 0);
    run_stream(1, NB, -1);
    chk_done();

    // 4: reset after 50 beats, then refill with new data
    do_reset();
    fill(2, 1);
    run_stream(0, 50, -1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    fill(0, 0);
    for (int i = 0; i < S*S; i++)
      for (int ch = 0; ch < L; ch++) px[i][ch] = pix(0, i, ch);
    run_stream(1, NB, -1);
    chk_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pool_fmap_window_reader.md
# pool_fmap_window_reader

Receives the pooled, ReLU'd feature map that the first CNN layer streams out, one pixel per strobe with all L channels in parallel. Buffers a full S×S map per channel, then reads it back as K×K sliding windows in row-major order for the next convolution layer. The block sits between the layer-1 output stage and the layer-2 MAC array: it is the reader at the far end of layer 1's write stream.

## Interface
**Parameters**
- `L`, 10: channels; one 13-bit lane each.
- `S`, 6: input map side, i.e. the pooled size (N-M+1)/2.
- `K`, 3: next-layer kernel side; requires K ≤ S.
- `W`, 13: signed data width.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: one map pixel is present on `in_data` this cycle.
- `in_data`, in, L*W: channel c occupies bits [c*W +: W]. Channel 0 is the layer-1 first output.
- `win_data`, out, L*W: window element, same lane packing as `in_data`.
- `win_valid`, out, 1: `win_data` and the tags are valid.
- `win_ready`, in, 1: consumer accepts the current beat.
- `win_first`, out, 1: beat is element (0,0) of a window.
- `win_last`, out, 1: beat is element (K-1,K-1) of a window.
- `win_row`, out, clog2(S): output row r of the current window.
- `win_col`, out, clog2(S): output column c of the current window.
- `buf_full`, out, 1: all S*S pixels are captured.
- `ovf`, out, 1: sticky; set when `in_valid` arrives outside FILL.
- `done`, out, 1: all windows delivered; held until `rst`.

## Operation
**FILL state** (entered at reset)
- On each `in_valid`, write `in_data` at `wr_ptr` and increment `wr_ptr`.
- The strobe with `wr_ptr` = S*S-1 sets `buf_full` and moves to STREAM.
- No ready/backpressure on the input side, because layer 1 cannot stall.

**STREAM state**
- Nested counters, outermost first: r, c over 0..S-K; kr, kc over 0..K-1.
- Read address = (r+kr)*S + (c+kc).
- A beat advances only when `win_valid && win_ready`.
- `win_first` = (kr==0 && kc==0). `win_last` = (kr==K-1 && kc==K-1).
- After the last beat of window (S-K, S-K) is accepted: go to DONE, set `done` = 1, set `win_valid` = 0.
- Total beats = (S-K+1)² · K² (144 at defaults).

**DONE state**
- Idle until `rst`. `buf_full` stays 1.

**In all states**
- `in_valid` while not in FILL sets `ovf` and is otherwise ignored; buffer contents are unchanged.
- Data passes through bit-exact, signed, with no arithmetic.
- Counter widths are clog2 of their ranges.

## Timing
**Reset values:** every output is 0; `wr_ptr` and all counters are 0; state is FILL. Buffer contents are don't-care and are not cleared.

**Read latency:** the RAM read is registered, so the first `win_valid` rises 2 cycles after the cycle that sets `buf_full`.
- One cycle is spent issuing the address, one is the RAM output register.
- Prefetch keeps throughput at 1 beat/cycle while `win_ready` is held high.

**Handshake rules**
- While `win_valid && !win_ready`, `win_data`, `win_first`, `win_last`, `win_row` and `win_col` hold stable.
- `win_valid` never drops before acceptance, except on `rst`.

**Boundary conditions**
- An `in_valid` strobe on the cycle `rst` is high is ignored.
- Reset mid-FILL or mid-STREAM: next cycle is FILL with all outputs 0; a fresh S*S strobes are required.
- The upstream cadence of one pixel every 2 cycles, or any irregular gaps, is tolerated.

## Structure
**Shared package `cnn_pkg`**
- Data width `W` = 13.
- State encoding: FILL, STREAM, DONE.
- Default L, S, K.
- Helper constant NWIN = (S-K+1)².

**Sub-module `fmap_ram`**
- L*W wide, S*S deep.
- One synchronous write port, one synchronous registered read port.
- Read enable is driven by the prefetch/stall logic in the top module.

## Test plan
- **Fill and first window.** Fill 36 pixels with channel c = c*100 + index, pixel every other cycle.
  - `buf_full` rises after the 36th strobe.
  - First window ch0 = 0,1,2,6,7,8,12,13,14; ch9 = 900,901,902,906,…,914.
  - `win_first` set on beat 0 only, `win_last` on beat 8 only; `win_row` = 0, `win_col` = 0.
- **Random backpressure.** Toggle `win_ready` randomly.
  - Beats are stable while stalled; exactly 144 beats are accepted.
  - Last window is (3,3) with ch0 = 21,22,23,27,28,29,33,34,35; `done` rises after its acceptance.
- **Signed extremes.** Pixels of -4096 and 4095 on alternating channels are reproduced bit-exact in `win_data`.
- **Reset mid-stream.** Assert `rst` after 50 accepted beats.
  - Next cycle all outputs are 0 and the block is back in FILL.
  - Refill with new data and receive 144 correct beats.
- **Stray input.** An extra `in_valid` during STREAM and during DONE sets `ovf`; the window data is uncorrupted.
- **Ready held high.** `win_valid` stays continuously high across all 144 beats, with `win_ready` tied to 1 throughout.
